operand_sequencer: RTL and testbench

Sequential front end for the combinational n-bit add/subtract stage. Captures two operands and an operation select from the board switches on successive presses of a load button, and drives them onto the adder's x, y and sub inputs. It then registers the adder's sum, cout and ovr into a stable result bank for the display stage. It is the adder's immediate upstream feeder and its immediate downstream capture register.

---
 rtl/operand_sequencer.sv | 93 +++++++++
 tb/tb_operand_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Operand/result sequencer around the combinational add/subtract stage.
// Loads A, then B with the op select, waits one cycle for the adder, then banks the result.
module operand_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         op_sub,
  input  logic         load,
  input  logic         clear,
  output logic [N-1:0] add_x,
  output logic [N-1:0] add_y,
  output logic         add_sub,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  input  logic         add_ovr,
  output logic [N-1:0] result,
  output logic         result_cout,
  output logic         result_ovr,
  output logic         result_valid,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    StLoadA = 2'b00,
    StLoadB = 2'b01,
    StExec  = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e state_q;
  logic   load_prev_q;
  logic   load_event;

  // load_prev resets high so a button held through reset must be released first.
  assign load_event = load & ~load_prev_q;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoadA;
      load_prev_q  <= 1'b1;
      add_x        <= '0;
      add_y        <= '0;
      add_sub      <= 1'b0;
      result       <= '0;
      result_cout  <= 1'b0;
      result_ovr   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      load_prev_q <= load;
      if (clear) begin
        // Abort only: operand and result registers keep their contents.
        state_q      <= StLoadA;
        result_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StLoadA: begin
            if (load_event) begin
              add_x   <= data_in;
              state_q <= StLoadB;
            end
          end
          StLoadB: begin
            if (load_event) begin
              add_y   <= data_in;
              add_sub <= op_sub;
              state_q <= StExec;
            end
          end
          StExec: begin
            // Operands have been stable for a full period; capture the adder outputs.
            result       <= add_sum;
            result_cout  <= add_cout;
            result_ovr   <= add_ovr;
            result_valid <= 1'b1;
            state_q      <= StDone;
          end
          StDone: begin
            if (load_event) begin
              add_x        <= data_in;
              result_valid <= 1'b0;
              state_q      <= StLoadB;
            end
          end
          default: state_q <= StLoadA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with a behavioural adder on the add_* bus.
module tb_operand_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] data_in;
  logic         op_sub;
  logic         load;
  logic         clear;
  logic [N-1:0] add_x;
  logic [N-1:0] add_y;
  logic         add_sub;
  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         add_ovr;
  logic [N-1:0] result;
  logic         result_cout;
  logic         result_ovr;
  logic         result_valid;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_sequencer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .op_sub      (op_sub),
    .load        (load),
    .clear       (clear),
    .add_x       (add_x),
    .add_y       (add_y),
    .add_sub     (add_sub),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .add_ovr     (add_ovr),
    .result      (result),
    .result_cout (result_cout),
    .result_ovr  (result_ovr),
    .result_valid(result_valid),
    .state       (state)
  );

  // Environment adder: x + (y ^ sub) + sub.
  logic [N:0] full;
  always_comb begin
    full     = {1'b0, add_x} + {1'b0, add_y ^ {N{add_sub}}} + (N + 1)'(add_sub);
    add_sum  = full[N-1:0];
    add_cout = full[N];
    add_ovr  = (add_x[N-1] == (add_y[N-1] ^ add_sub)) && (full[N-1] != add_x[N-1]);
  end

  // Reference arithmetic from integer values: returns {ovr, cout, sum}.
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic s);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [N-1:0] sum;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
    sb = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= 2 ** N);
      sr = sa + sb;
    end
    v   = (sr > 2 ** (N - 1) - 1) || (sr < -(2 ** (N - 1)));
    sum = r[N-1:0];
    return {v, c, sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from LOAD_A or DONE with load low on entry.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input string name);
    logic [N+1:0] exp;
    logic [N-1:0] prev_result;
    exp         = ref_op(a, b, s);
    prev_result = result;
    data_in = a;
    load    = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (add_x !== a || state !== 2'b01 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_load_a: add_x=%0d state=%0d valid=%0d expected %0d/1/0",
               name, add_x, state, result_valid, a);
    end
    checks++;
    if (result !== prev_result) begin
      errors++;
      $display("FAIL %s_old_result: got %0d expected %0d", name, result, prev_result);
    end
    tick();
    data_in = b;
    op_sub  = s;
    load    = 1'b1;
    tick();
    checks++;
    if (state !== 2'b10 || add_y !== b || add_sub !== s || add_x !== a) begin
      errors++;
      $display("FAIL %s_exec: state=%0d y=%0d sub=%0d x=%0d expected 2/%0d/%0d/%0d",
               name, state, add_y, add_sub, add_x, b, s, a);
    end
    // Flip op_sub and change data while load stays high through EXEC.
    op_sub  = ~s;
    data_in = ~b;
    tick();
    checks++;
    if (state !== 2'b11 || result_valid !== 1'b1 || result !== exp[N-1:0] ||
        result_cout !== exp[N] || result_ovr !== exp[N+1]) begin
      errors++;
      $display("FAIL %s_done: state=%0d valid=%0d res=%0d c=%0d v=%0d expected 3/1/%0d/%0d/%0d",
               name, state, result_valid, result, result_cout, result_ovr,
               exp[N-1:0], exp[N], exp[N+1]);
    end
    checks++;
    if (add_sub !== s || add_x !== a || add_y !== b) begin
      errors++;
      $display("FAIL %s_operands_held: x=%0d y=%0d sub=%0d expected %0d/%0d/%0d",
               name, add_x, add_y, add_sub, a, b, s);
    end
    load = 1'b0;
    tick();
    checks++;
    if (state !== 2'b11 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_hold: state=%0d valid=%0d expected 3/1", name, state, result_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; load = 1'b1; data_in = 4'd5; op_sub = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00 || add_x !== 0 || add_y !== 0 || add_sub !== 0 || result !== 0 ||
        result_cout !== 0 || result_ovr !== 0 || result_valid !== 0) begin
      errors++;
      $display("FAIL reset_values: state=%0d x=%0d y=%0d sub=%0d res=%0d c=%0d v=%0d valid=%0d expected all 0",
               state, add_x, add_y, add_sub, result, result_cout, result_ovr, result_valid);
    end
    tick();
    checks++;
    if (state !== 2'b00 || add_x !== 0) begin
      errors++;
      $display("FAIL reset_held_load: state=%0d x=%0d expected 0/0", state, add_x);
    end
    load = 1'b0;
    tick();
    data_in = 4'd9;
    load    = 1'b1;
    tick();
    checks++;
    if (state !== 2'b01 || add_x !== 4'd9) begin
      errors++;
      $display("FAIL reset_first_press: state=%0d x=%0d expected 1/9", state, add_x);
    end
    load = 1'b0;
    tick();
    // Return to LOAD_A for the next scenario.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_clear_back: state=%0d expected 0", state);
    end
  endtask

  task automatic test_add();
    run_op(4'd3, 4'd5, 1'b0, "add");
    checks++;
    if (result !== 4'd8) begin
      errors++;
      $display("FAIL add_value: got %0d expected 8", result);
    end
  endtask

  task automatic test_sub();
    run_op(4'd2, 4'd6, 1'b1, "sub");
    checks++;
    if (result !== 4'd12 || result_cout !== 1'b0 || result_ovr !== 1'b0) begin
      errors++;
      $display("FAIL sub_value: res=%0d c=%0d v=%0d expected 12/0/0",
               result, result_cout, result_ovr);
    end
  endtask

  task automatic test_clear_load();
    logic [N-1:0] old_y;
    old_y   = add_y;
    data_in = 4'd7;
    load    = 1'b1;
    tick();
    load = 1'b0;
    tick();
    data_in = ~old_y;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    checks++;
    if (state !== 2'b00 || add_y !== old_y || result_valid !== 1'b0 || add_x !== 4'd7) begin
      errors++;
      $display("FAIL clear_load: state=%0d y=%0d valid=%0d x=%0d expected 0/%0d/0/7",
               state, add_y, result_valid, add_x, old_y);
    end
    clear = 1'b0;
    load  = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL clear_stays: state=%0d expected 0", state);
    end
  endtask

  task automatic test_rst_exec();
    data_in = 4'd4;
    load    = 1'b1;
    tick();
    load = 1'b0;
    tick();
    data_in = 4'd11;
    op_sub  = 1'b1;
    load    = 1'b1;
    tick();
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL rst_exec_reach: state=%0d expected 2", state);
    end
    rst   = 1'b1;
    clear = 1'b1;
    tick();
    checks++;
    if (state !== 2'b00 || add_x !== 0 || add_y !== 0 || add_sub !== 0 || result !== 0 ||
        result_cout !== 0 || result_ovr !== 0 || result_valid !== 0) begin
      errors++;
      $display("FAIL rst_exec_values: state=%0d x=%0d y=%0d sub=%0d res=%0d c=%0d v=%0d valid=%0d expected all 0",
               state, add_x, add_y, add_sub, result, result_cout, result_ovr, result_valid);
    end
    rst   = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    tick();
    run_op(4'd13, 4'd6, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    logic s;
    for (int i = 0; i < 24; i++) begin
      a = N'($urandom_range(0, 2 ** N - 1));
      b = N'($urandom_range(0, 2 ** N - 1));
      s = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      run_op(a, b, s, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_clear_load();
    test_rst_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
